// File: rtl/reward_gen_pkg.sv
// Shared definitions for the reward generator: reward codes, the jump
// lifecycle state enum, the "no cactus" distance value and a saturating
// increment used by the optional statistics counters (REWARD_STATS_EN).
package reward_gen_pkg;

  // Reward codes presented on the one-cycle 'state' output.
  localparam logic [1:0] REW_NONE    = 2'b00;
  localparam logic [1:0] REW_GOOD    = 2'b01;
  localparam logic [1:0] REW_NOJUMP  = 2'b10;
  localparam logic [1:0] REW_BADJUMP = 2'b11;

  // Distance reported when no cactus is on screen.
  localparam logic [9:0] DIST_FAR = 10'd1023;

  // Jump lifecycle.
  //   IDLE   : menu / restart, nothing is reported
  //   GROUND : dino on the ground, watching for takeoff or a hit
  //   AIR    : jump in flight, outcome not yet known
  //   LAND   : landed, outcome still open for a bounded settle window
  //   DONE   : outcome already reported, waiting for the dino to land
  //   DEAD   : collision seen, frozen until the game restarts
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GROUND = 3'd1,
    ST_AIR    = 3'd2,
    ST_LAND   = 3'd3,
    ST_DONE   = 3'd4,
    ST_DEAD   = 3'd5
  } fsm_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end
    return value + 16'd1;
  endfunction

endpackage

// File: rtl/reward_gen_dist.sv
// dist_calc: registered distance from the dino to the nearest cactus.
// Far value when no cactus is present, zero once the cactus has reached or
// passed the dino, otherwise the plain pixel difference (cannot wrap because
// the subtraction only happens when cactus_x > DINO_X).
module dist_calc
  import reward_gen_pkg::*;
#(
  parameter logic [9:0] DINO_X = 10'd80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cactus_valid,
  input  logic [9:0] cactus_x,
  output logic [9:0] distance
);

  logic [9:0] distance_d;

  // Clamp/subtract on the raw engine coordinates.
  always_comb begin
    distance_d = DIST_FAR;
    if (!cactus_valid) begin
      distance_d = DIST_FAR;
    end else if (cactus_x <= DINO_X) begin
      distance_d = 10'd0;
    end else begin
      distance_d = cactus_x - DINO_X;
    end
  end

  // One-cycle registered output, aligned with the other reward_gen outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      distance <= DIST_FAR;
    end else begin
      distance <= distance_d;
    end
  end

endmodule

// File: rtl/reward_gen.sv
// reward_gen: converts raw game-engine signals into the Q-learning bot's
// inputs (distance, cactus type, takeoff strobe, reward code) and tracks each
// jump through a lifecycle FSM so exactly one outcome is reported per jump or
// per collision.
//
// Optional feature: define REWARD_STATS_EN to add saturating good_cnt and
// bad_cnt outputs. Without it those ports and their logic do not exist and
// the FSM behaves identically.
//
// Output contract: every output is registered from the inputs sampled at the
// same clock edge, so success_jump is high in exactly the cycle in which
// distance/cactus show the takeoff-cycle values; the bot may latch all three
// together on success_jump without any extra alignment. success_jump and
// state are single-cycle strobes with no back-pressure.
module reward_gen
  import reward_gen_pkg::*;
#(
  parameter logic [9:0]  DINO_X        = 10'd80,
  parameter logic [15:0] SETTLE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_active,
  input  logic       dino_airborne,
  input  logic       collision,
  input  logic       cactus_valid,
  input  logic [9:0] cactus_x,
  input  logic [2:0] cactus_type,
  input  logic       cactus_passed,
  output logic [9:0] distance,
  output logic [2:0] cactus,
  output logic       success_jump,
  output logic [1:0] state,
`ifdef REWARD_STATS_EN
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
`endif
  output fsm_state_t fsm_state
);

  // Last settle count before giving up on a landed jump.
  localparam logic [15:0] SETTLE_LAST = SETTLE_CYCLES - 16'd1;

  fsm_state_t  fsm_q, fsm_d;
  logic [15:0] settle_q, settle_d;
  logic        airborne_q;
  logic        rise, fall;
  logic        success_jump_d;
  logic [1:0]  reward_d;

  assign fsm_state = fsm_q;

  assign rise = dino_airborne & ~airborne_q;
  assign fall = ~dino_airborne & airborne_q;

  dist_calc #(
    .DINO_X(DINO_X)
  ) u_dist_calc (
    .clk         (clk),
    .reset       (reset),
    .cactus_valid(cactus_valid),
    .cactus_x    (cactus_x),
    .distance    (distance)
  );

  // Lifecycle next state and the strobes it produces. Collision has the
  // highest priority, then cactus_passed, then takeoff/landing edges, then
  // the settle timeout; this keeps at most one code per cycle.
  always_comb begin
    fsm_d          = fsm_q;
    settle_d       = settle_q;
    success_jump_d = 1'b0;
    reward_d       = REW_NONE;

    if (!game_active) begin
      fsm_d    = ST_IDLE;
      settle_d = 16'd0;
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          fsm_d = ST_GROUND;
        end

        ST_GROUND: begin
          if (collision) begin
            reward_d = REW_NOJUMP;
            fsm_d    = ST_DEAD;
          end else if (rise) begin
            success_jump_d = 1'b1;
            fsm_d          = ST_AIR;
          end
        end

        ST_AIR: begin
          if (collision) begin
            reward_d = REW_BADJUMP;
            fsm_d    = ST_DEAD;
          end else if (cactus_passed) begin
            reward_d = REW_GOOD;
            fsm_d    = ST_DONE;
          end else if (fall) begin
            settle_d = 16'd0;
            fsm_d    = ST_LAND;
          end
        end

        ST_LAND: begin
          if (collision) begin
            reward_d = REW_BADJUMP;
            fsm_d    = ST_DEAD;
          end else if (cactus_passed) begin
            reward_d = REW_GOOD;
            fsm_d    = ST_GROUND;
          end else if (rise) begin
            // New takeoff abandons the open jump without reporting it.
            success_jump_d = 1'b1;
            fsm_d          = ST_AIR;
          end else if (settle_q == SETTLE_LAST) begin
            fsm_d = ST_GROUND;
          end else begin
            settle_d = settle_q + 16'd1;
          end
        end

        ST_DONE: begin
          if (collision) begin
            fsm_d = ST_DEAD;
          end else if (fall) begin
            fsm_d = ST_GROUND;
          end
        end

        ST_DEAD: begin
          fsm_d = ST_DEAD;
        end

        default: begin
          fsm_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, edge detector and settle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= ST_IDLE;
      settle_q   <= 16'd0;
      airborne_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      settle_q   <= settle_d;
      airborne_q <= dino_airborne;
    end
  end

  // Registered bot-facing outputs, all from the same sampled inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cactus       <= 3'd0;
      success_jump <= 1'b0;
      state        <= REW_NONE;
    end else begin
      cactus       <= cactus_type;
      success_jump <= success_jump_d;
      state        <= reward_d;
    end
  end

`ifdef REWARD_STATS_EN
  // Outcome statistics; they move in the same cycle the code appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else begin
      if (reward_d == REW_GOOD) begin
        good_cnt <= sat_inc16(good_cnt);
      end
      if ((reward_d == REW_NOJUMP) || (reward_d == REW_BADJUMP)) begin
        bad_cnt <= sat_inc16(bad_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reward_gen.sv
// Bench for reward_gen: directed scenarios followed by random game traffic,
// every cycle compared against a behavioural model of the jump lifecycle.
module tb_reward_gen;
  import reward_gen_pkg::*;

  localparam int SETTLE = 8;
  localparam int DINO   = 80;

  // Clock / reset signals and DUT inputs.
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_active = 1'b0;
  logic       dino_airborne = 1'b0;
  logic       collision = 1'b0;
  logic       cactus_valid = 1'b0;
  logic [9:0] cactus_x = 10'd0;
  logic [2:0] cactus_type = 3'd0;
  logic       cactus_passed = 1'b0;

  logic [9:0] distance;
  logic [2:0] cactus;
  logic       success_jump;
  logic [1:0] state;
  fsm_state_t fsm_state;
`ifdef REWARD_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  always #5 clk = ~clk;

  reward_gen #(
    .DINO_X       (10'd80),
    .SETTLE_CYCLES(16'(SETTLE))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .game_active  (game_active),
    .dino_airborne(dino_airborne),
    .collision    (collision),
    .cactus_valid (cactus_valid),
    .cactus_x     (cactus_x),
    .cactus_type  (cactus_type),
    .cactus_passed(cactus_passed),
    .distance     (distance),
    .cactus       (cactus),
    .success_jump (success_jump),
    .state        (state),
`ifdef REWARD_STATS_EN
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt),
`endif
    .fsm_state    (fsm_state)
  );

  // Scoreboard: expected {distance, cactus, success_jump, state}.
  logic [15:0] exp_q[$];
  logic [31:0] exp_stats_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: the game as the bot sees it, kept as plain flags.
  bit in_game, dead, jump_open, landed, reported, prev_air;
  int wait_cnt;
  int good_n, bad_n;

  task automatic model_clear();
    in_game   = 0;
    dead      = 0;
    jump_open = 0;
    landed    = 0;
    reported  = 0;
    wait_cnt  = 0;
  endtask

  task automatic model_step(input bit rst, input bit ga, input bit air, input bit col,
                            input bit cv, input int cx, input int ct, input bit pass);
    int  d;
    int  code;
    bit  sj;
    bit  up, down;
    code = 0;
    sj   = 0;
    if (rst) begin
      model_clear();
      prev_air = 0;
      good_n   = 0;
      bad_n    = 0;
      exp_q.push_back({10'd1023, 3'd0, 1'b0, 2'b00});
      exp_stats_q.push_back(32'd0);
      return;
    end
    if (!cv)            d = 1023;
    else if (cx <= DINO) d = 0;
    else                d = cx - DINO;
    up   = air && !prev_air;
    down = !air && prev_air;
    if (!ga) begin
      model_clear();
    end else if (!in_game) begin
      in_game = 1;
    end else if (dead) begin
      code = 0;
    end else if (reported) begin
      if (col) begin
        reported = 0;
        dead     = 1;
      end else if (down) begin
        reported = 0;
      end
    end else if (jump_open && !landed) begin
      if (col) begin
        code = 3; dead = 1; jump_open = 0;
      end else if (pass) begin
        code = 1; jump_open = 0; reported = 1;
      end else if (down) begin
        landed = 1; wait_cnt = 0;
      end
    end else if (jump_open) begin
      if (col) begin
        code = 3; dead = 1; jump_open = 0;
      end else if (pass) begin
        code = 1; jump_open = 0;
      end else if (up) begin
        sj = 1; landed = 0;
      end else if (wait_cnt == SETTLE - 1) begin
        jump_open = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      if (col) begin
        code = 2; dead = 1;
      end else if (up) begin
        sj = 1; jump_open = 1; landed = 0;
      end
    end
    prev_air = air;
    if (code == 1 && good_n < 65535) good_n++;
    if (code >= 2 && bad_n < 65535)  bad_n++;
    exp_q.push_back({10'(d), 3'(ct), sj, 2'(code)});
    exp_stats_q.push_back({16'(good_n), 16'(bad_n)});
  endtask

  // Driver: apply one cycle of inputs, predict, then compare after the edge.
  task automatic step(input bit rst, input bit ga, input bit air, input bit col,
                      input bit cv, input int cx, input int ct, input bit pass);
    logic [15:0] e;
    logic [31:0] es;
    reset         = rst;
    game_active   = ga;
    dino_airborne = air;
    collision     = col;
    cactus_valid  = cv;
    cactus_x      = 10'(cx);
    cactus_type   = 3'(ct);
    cactus_passed = pass;
    model_step(rst, ga, air, col, cv, cx, ct, pass);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    es = exp_stats_q.pop_front();
    check_eq("distance", distance, e[15:6]);
    check_eq("cactus", cactus, e[5:3]);
    check_eq("success_jump", success_jump, e[2]);
    check_eq("state", state, e[1:0]);
`ifdef REWARD_STATS_EN
    check_eq("good_cnt", good_cnt, es[31:16]);
    check_eq("bad_cnt", bad_cnt, es[15:0]);
`else
    es = es;
`endif
  endtask

  // Shorthand for a game-running cycle with a cactus at x=200, type 2.
  task automatic play(input bit air, input bit col, input bit pass);
    step(0, 1, air, col, 1, 200, 2, pass);
  endtask

  // Restart the game: one cycle with game_active low, one to enter GROUND.
  task automatic restart();
    step(0, 0, 0, 0, 1, 200, 2, 0);
    step(0, 1, 0, 0, 1, 200, 2, 0);
  endtask

  initial begin
    bit air_r;
    // Reset block.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_distance", distance, 1023);
    check_eq("rst_state", state, 0);
    check_eq("rst_sj", success_jump, 0);

    // Distance clamp/subtract.
    step(0, 1, 0, 0, 1, 300, 5, 0);
    check_eq("dist_300", distance, 220);
    check_eq("cactus_5", cactus, 5);
    step(0, 1, 0, 0, 1, 50, 1, 0);
    check_eq("dist_50", distance, 0);
    step(0, 1, 0, 0, 1, 80, 1, 0);
    check_eq("dist_80", distance, 0);
    step(0, 1, 0, 0, 0, 300, 1, 0);
    check_eq("dist_invalid", distance, 1023);

    // Good jump: takeoff, cactus passed in air, landing.
    play(1, 0, 0);
    check_eq("takeoff_sj", success_jump, 1);
    check_eq("takeoff_dist", distance, 120);
    play(1, 0, 0);
    check_eq("sj_one_cycle", success_jump, 0);
    play(1, 0, 1);
    check_eq("good_code", state, REW_GOOD);
    play(1, 0, 0);
    check_eq("good_one_cycle", state, REW_NONE);
    play(0, 0, 0);
    play(0, 0, 0);

    // Hit without jumping, then DEAD ignores further hits.
    play(0, 1, 0);
    check_eq("nojump_code", state, REW_NOJUMP);
    play(0, 1, 0);
    check_eq("dead_silent", state, REW_NONE);
    restart();

    // Collision and rise together in GROUND: collision wins.
    play(1, 1, 0);
    check_eq("colrise_code", state, REW_NOJUMP);
    check_eq("colrise_sj", success_jump, 0);
    restart();

    // Collision in the air.
    play(1, 0, 0);
    play(1, 1, 0);
    check_eq("air_hit", state, REW_BADJUMP);
    restart();

    // Collision after landing, inside the settle window.
    play(1, 0, 0);
    play(0, 0, 0);
    repeat (4) play(0, 0, 0);
    play(0, 1, 0);
    check_eq("land_hit", state, REW_BADJUMP);
    restart();

    // Settle timeout: no code, then a hit counts as no-jump from GROUND.
    play(1, 0, 0);
    play(0, 0, 0);
    repeat (SETTLE) begin
      play(0, 0, 0);
      check_eq("settle_quiet", state, REW_NONE);
    end
    play(0, 1, 0);
    check_eq("timeout_then_nojump", state, REW_NOJUMP);
    restart();

    // Re-takeoff inside the window abandons the old jump.
    play(1, 0, 0);
    play(0, 0, 0);
    repeat (3) play(0, 0, 0);
    play(1, 0, 0);
    check_eq("retake_sj", success_jump, 1);
    check_eq("retake_code", state, REW_NONE);
    play(1, 0, 1);
    check_eq("retake_good", state, REW_GOOD);
    play(0, 0, 0);

    // Reset mid-air discards the jump.
    play(1, 0, 0);
    play(1, 0, 0);
    step(1, 1, 1, 0, 1, 200, 2, 1);
    check_eq("midair_rst_state", state, REW_NONE);
    check_eq("midair_rst_dist", distance, 1023);
    step(0, 1, 0, 0, 1, 200, 2, 0);

    // Random game traffic.
    air_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) air_r = !air_r;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) != 0,
           air_r,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 7) != 0,
           int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 14) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reward_gen.md
# reward_gen

- Upstream stage of the Q-learning bot; turns raw game-engine signals into the bot's inputs:
  - quantised cactus distance and cactus type
  - a takeoff strobe
  - the 2-bit reward code
- Tracks each jump through a small lifecycle FSM and emits exactly one outcome code per jump or per collision.

## Interface
Parameters:
- DINO_X, 10'd80, fixed dino x-coordinate in pixels
- SETTLE_CYCLES, 16'd50000, post-landing window for resolving a jump outcome
Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- game_active  in  1  game running; low = menu or restart
- dino_airborne  in  1  dino feet off ground
- collision  in  1  single-cycle pulse on dino/cactus hit
- cactus_valid  in  1  a cactus is on screen
- cactus_x  in  10  left edge of nearest cactus
- cactus_type  in  3  type of nearest cactus
- cactus_passed  in  1  single-cycle pulse when nearest cactus clears the dino
- distance  out  10  registered distance to nearest cactus
- cactus  out  3  registered cactus_type
- success_jump  out  1  one-cycle takeoff strobe
- state  out  2  one-cycle reward code:
  - 00 none
  - 01 good jump
  - 10 hit without jumping
  - 11 bad jump
- good_cnt, bad_cnt  out  16 each  present only with REWARD_STATS_EN

## Operation
Distance, every cycle:
- !cactus_valid -> 1023
- cactus_x <= DINO_X -> 0
- otherwise cactus_x - DINO_X (10-bit, no wrap)

Edge detection:
- rise = dino_airborne & !airborne_q
- fall = !dino_airborne & airborne_q

FSM states and transitions:
- IDLE
  - game_active -> GROUND
- GROUND
  - collision -> state=10, go DEAD
  - else rise -> success_jump=1, go AIR
  - collision and rise in the same cycle: collision wins; no success_jump
- AIR
  - collision -> 11, DEAD
  - else cactus_passed -> 01, DONE
  - else fall -> LAND; settle counter cleared
- LAND
  - collision -> 11, DEAD
  - else cactus_passed -> 01, GROUND
  - else rise -> success_jump, AIR; prior jump abandoned with no code
  - else counter == SETTLE_CYCLES-1 -> GROUND with no code
  - otherwise counter +1
- DONE (outcome already reported, waiting to land)
  - collision -> DEAD with no code
  - fall -> GROUND
- DEAD
  - holds until game_active low

Global rules:
- game_active low forces IDLE from any state.
- In IDLE no strobes are emitted.
- At most one non-zero state code per cycle.
- Priority: collision > cactus_passed > edges > timeout.

## Timing
- All outputs registered; one-cycle latency from the sampled inputs.
- success_jump is high in the same cycle that distance and cactus show the takeoff-cycle values, so the downstream bot latches a consistent pair.
- state codes are one cycle wide and return to 00 the next cycle.
- Reset values:
  - distance = 1023, cactus = 0, success_jump = 0, state = 00
  - FSM = IDLE, airborne_q = 0, settle counter = 0
  - stats counters = 0
- Reset mid-jump discards the jump silently.

## Configuration
REWARD_STATS_EN:
- Defined:
  - good_cnt increments on every 01.
  - bad_cnt increments on every 10 or 11.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined:
  - Ports and logic are absent.
  - FSM behaviour is identical.

## Structure
- Shared package holds:
  - reward code constants: REW_NONE=2'b00, REW_GOOD=2'b01, REW_NOJUMP=2'b10, REW_BADJUMP=2'b11
  - the FSM state enum
  - DIST_FAR = 10'd1023
- One sub-module: dist_calc, the registered clamp/subtract for the distance output.

## Test plan
- game_active=1, cactus_x=300 -> distance=220 next cycle. cactus_x=50 -> distance=0. cactus_valid=0 -> distance=1023.
- Rise at cactus_x=200 -> success_jump=1 with distance=120. Later cactus_passed while airborne -> state=01 for one cycle, then DONE. Landing -> GROUND.
- GROUND with no jump, collision pulse -> state=10. FSM DEAD; further collisions produce 00. game_active low then high -> GROUND.
- Jump, then collision while airborne -> state=11. Jump, land, collision 10 cycles later -> state=11.
- Jump, land, no events for SETTLE_CYCLES (small override, e.g. 8) -> no code, back to GROUND. Re-takeoff inside the window -> new success_jump and no code for the old jump.
- With REWARD_STATS_EN: 3 good jumps and 2 collisions -> good_cnt=3, bad_cnt=2. Forcing good_cnt to FFFF then another good jump -> stays FFFF. Reset mid-AIR -> all outputs at reset values and no code emitted.
